regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Write-side initiator for the CPU core's single-write-port register file: merges in-order pipeline
//  writebacks with out-of-order long-latency results (mul/div, loads) into one we/waddr/wdata stream.
//  Buffers long-latency results in a small FIFO and tracks pending destinations in a busy scoreboard.
//  The issue stage uses busy/pipe_stall for hazard stalls. Sits between EX/MEM units and regfile.
// PARAMETERS
//  DEPTH         4   long-latency result FIFO entries (>=2, power of 2)
//  STARVE_LIMIT  4   cycles a non-empty FIFO head may wait before pipe_stall is raised (>=1)
// PORTS
//  clk          in   1   core clock; all state updates on posedge
//  resetn       in   1   asynchronous, active-low reset
//  pipe_we      in   1   in-order pipeline writeback valid; no backpressure
//  pipe_waddr   in   5   pipeline destination register
//  pipe_wdata   in   32  pipeline result
//  lr_valid     in   1   long-latency result valid
//  lr_ready     out  1   FIFO can accept (= count!=DEPTH)
//  lr_waddr     in   5   long-latency destination register
//  lr_wdata     in   32  long-latency result
//  issue_valid  in   1   a long-latency op issued this cycle
//  issue_waddr  in   5   its destination register
//  busy         out  32  per-register pending-long-latency-write bitmap
//  pipe_stall   out  1   registered; upstream must hold pipe_we=0 next cycle
//  rf_we        out  1   regfile write enable (registered)
//  rf_waddr     out  5   regfile write address (registered)
//  rf_wdata     out  32  regfile write data (registered)
//  waw_err      out  1   sticky protocol-violation flag
// BEHAVIOUR
//  Reset: rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, pipe_stall=0, waw_err=0, FIFO empty
//    (lr_ready=1), wait counter 0. Reset mid-operation discards FIFO contents and pending busy bits.
//  Enqueue: lr_valid & lr_ready at posedge pushes {waddr,wdata}. When full, lr_ready=0 even if a
//    dequeue happens the same cycle (no pass-through).
//  Arbitration per cycle: pipe_we=1 -> select pipe; else FIFO non-empty -> select and pop head;
//    else no write. Selected entry is registered into rf_* at posedge: latency 1 cycle from pipe_we,
//    >=1 cycle from enqueue (empty FIFO: enqueue cycle N, rf_we cycle N+1, regfile updated N+2 edge).
//  r0: a selected write with waddr==0 yields rf_we=0 but still pops/completes normally.
//  Scoreboard: issue_valid sets busy[issue_waddr] (never bit 0); a FIFO pop clears busy[head waddr].
//    Same-cycle set and clear of one bit: set wins. busy is a register (visible cycle after issue).
//  Starvation: wait counter increments (saturating at STARVE_LIMIT) each cycle FIFO non-empty and
//    no pop; clears on pop or empty. pipe_stall <= nonempty & (count==DEPTH | wait>=STARVE_LIMIT),
//    using post-update values.
//  waw_err set (sticky until reset) when: pipe_we & busy[pipe_waddr] & pipe_waddr!=0; or pipe_we
//    in a cycle where pipe_stall=1. Pipe still wins arbitration in both cases.
//  Widths: count is $clog2(DEPTH+1) bits; pointers $clog2(DEPTH) bits, wrap modulo DEPTH.
// STRUCTURE
//  Shared package: REG_AW=5, REG_DW=32, NREGS=32 constants; wb_entry_t {waddr, wdata} typedef.
//  One sub-module: wb_fifo (DEPTH x wb_entry_t, push/pop/full/empty/count). Scoreboard, arbiter and
//  starvation logic stay in the top.
// TESTING
//  1 Idle: only pipe_we=1,waddr=3,wdata=0xDEAD_BEEF -> next cycle rf_we=1,rf_waddr=3,
//    rf_wdata=0xDEADBEEF.
//  2 Conflict: pipe_we=1 (r4) and lr_valid=1 (r5,0x55) same cycle -> cycle+1 r4 written, cycle+2
//    r5=0x55; busy[5] set by earlier issue clears at the pop edge.
//  3 Starvation: FIFO holds 1 entry, pipe_we=1 every cycle -> pipe_stall=1 after 4 waiting cycles;
//    bench drops pipe_we -> entry written, pipe_stall falls.
//  4 Full: 4 enqueues with pipe busy -> lr_ready=0, pipe_stall=1; 5th lr_valid held until a pop.
//  5 r0/scoreboard: lr write to r0 -> rf_we=0, FIFO pops; issue_valid & pop same reg same cycle ->
//    busy bit stays 1.
//  6 Errors/reset: pipe_we to busy r7 -> waw_err=1 sticky; resetn low with 3 entries queued ->
//    FIFO empty, busy=0, rf_we=0 immediately.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and writeback entry type for the register-file write arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned REG_DW = 32;
  localparam int unsigned NREGS  = 32;

  typedef struct packed {
    logic [REG_AW-1:0] waddr;
    logic [REG_DW-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small FIFO holding long-latency writeback entries until they win the write port.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push_i,
  input  wb_entry_t                  din_i,
  input  logic                       pop_i,
  output wb_entry_t                  dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  wb_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges in-order pipeline writebacks with buffered long-latency results onto the
// single regfile write port, tracking pending destinations and starvation of the FIFO.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_waddr,
  input  logic [REG_DW-1:0] pipe_wdata,
  input  logic              lr_valid,
  output logic              lr_ready,
  input  logic [REG_AW-1:0] lr_waddr,
  input  logic [REG_DW-1:0] lr_wdata,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_waddr,
  output logic [NREGS-1:0]  busy,
  output logic              pipe_stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [REG_DW-1:0] rf_wdata,
  output logic              waw_err
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned WW = $clog2(STARVE_LIMIT+1);

  wb_entry_t         lr_entry, head;
  logic              fifo_full, fifo_empty, push, pop;
  logic [CW-1:0]     fifo_count, count_d;
  logic [WW-1:0]     starve_q, starve_d;
  logic [NREGS-1:0]  busy_q, busy_d, set_v, clr_v;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [REG_DW-1:0] rf_wdata_q, rf_wdata_d;
  logic              stall_q, stall_d, waw_q, waw_d;

  assign lr_entry = '{waddr: lr_waddr, wdata: lr_wdata};
  assign lr_ready = ~fifo_full;
  assign push     = lr_valid & ~fifo_full;
  assign pop      = ~pipe_we & ~fifo_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .din_i   (lr_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pipe_we) begin
      rf_we_d    = (pipe_waddr != '0);
      rf_waddr_d = pipe_waddr;
      rf_wdata_d = pipe_wdata;
    end else if (pop) begin
      rf_we_d    = (head.waddr != '0);
      rf_waddr_d = head.waddr;
      rf_wdata_d = head.wdata;
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit pending.
    set_v = '0;
    clr_v = '0;
    if (issue_valid && issue_waddr != '0) set_v[issue_waddr] = 1'b1;
    if (pop) clr_v[head.waddr] = 1'b1;
    busy_d = (busy_q & ~clr_v) | set_v;

    count_d = fifo_count;
    if (push && !pop)      count_d = fifo_count + CW'(1);
    else if (pop && !push) count_d = fifo_count - CW'(1);

    if (pop || fifo_empty)                  starve_d = '0;
    else if (starve_q < WW'(STARVE_LIMIT))  starve_d = starve_q + WW'(1);
    else                                    starve_d = starve_q;

    stall_d = (count_d != '0) &&
              ((count_d == CW'(DEPTH)) || (starve_d >= WW'(STARVE_LIMIT)));

    waw_d = waw_q |
            (pipe_we & ((busy_q[pipe_waddr] & (pipe_waddr != '0)) | stall_q));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      waw_q      <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      waw_q      <= waw_d;
    end
  end

  assign busy       = busy_q;
  assign pipe_stall = stall_q;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign waw_err    = waw_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table plus hand sequences, writes scoreboarded.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        lr_valid;
  logic        lr_ready;
  logic [4:0]  lr_waddr;
  logic [31:0] lr_wdata;
  logic        issue_valid;
  logic [4:0]  issue_waddr;
  logic [31:0] busy;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        waw_err;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic        pwe; logic [4:0] pa; logic [31:0] pd;
    logic        lv;  logic [4:0] la; logic [31:0] ld;
    logic        iv;  logic [4:0] ia;
    logic        ewe; logic [4:0] ea; logic [31:0] ed;
  } vec_t;

  typedef struct {
    logic we; logic [4:0] a; logic [31:0] d;
  } exp_t;

  exp_t expq[$];
  vec_t tbl[8];

  regfile_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .pipe_we     (pipe_we),
    .pipe_waddr  (pipe_waddr),
    .pipe_wdata  (pipe_wdata),
    .lr_valid    (lr_valid),
    .lr_ready    (lr_ready),
    .lr_waddr    (lr_waddr),
    .lr_wdata    (lr_wdata),
    .issue_valid (issue_valid),
    .issue_waddr (issue_waddr),
    .busy        (busy),
    .pipe_stall  (pipe_stall),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .waw_err     (waw_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t V(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                             input logic lv, input logic [4:0] la, input logic [31:0] ld,
                             input logic iv, input logic [4:0] ia,
                             input logic ewe, input logic [4:0] ea, input logic [31:0] ed);
    vec_t v;
    v.pwe = pwe; v.pa = pa; v.pd = pd;
    v.lv  = lv;  v.la = la; v.ld = ld;
    v.iv  = iv;  v.ia = ia;
    v.ewe = ewe; v.ea = ea; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    lr_valid = 1'b0; lr_waddr = '0; lr_wdata = '0;
    issue_valid = 1'b0; issue_waddr = '0;
  endtask

  // Drive one cycle, queue the write expected at the next edge, then check it.
  task automatic run(input vec_t v);
    exp_t e;
    pipe_we = v.pwe; pipe_waddr = v.pa; pipe_wdata = v.pd;
    lr_valid = v.lv; lr_waddr = v.la; lr_wdata = v.ld;
    issue_valid = v.iv; issue_waddr = v.ia;
    expq.push_back('{we: v.ewe, a: v.ea, d: v.ed});
    @(posedge clk);
    #1;
    if (expq.size() == 0) begin
      nvec++; nerr++;
      $display("FAIL scoreboard: got empty queue required an entry");
    end else begin
      e = expq.pop_front();
      chk("rf_we", 32'(rf_we), 32'(e.we));
      if (e.we) begin
        chk("rf_waddr", 32'(rf_waddr), 32'(e.a));
        chk("rf_wdata", rf_wdata, e.d);
      end
    end
  endtask

  initial begin
    tbl[0] = V(1, 5'd3,  32'hDEAD_BEEF, 0, 5'd0, 32'h0,  0, 5'd0, 1, 5'd3,  32'hDEAD_BEEF);
    tbl[1] = V(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,  1, 5'd5, 0, 5'd0,  32'h0);
    tbl[2] = V(1, 5'd4,  32'h44,        1, 5'd5, 32'h55, 0, 5'd0, 1, 5'd4,  32'h44);
    tbl[3] = V(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,  0, 5'd0, 1, 5'd5,  32'h55);
    tbl[4] = V(0, 5'd0,  32'h0,         1, 5'd9, 32'h99, 0, 5'd0, 0, 5'd0,  32'h0);
    tbl[5] = V(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,  0, 5'd0, 1, 5'd9,  32'h99);
    tbl[6] = V(1, 5'd0,  32'h1,         0, 5'd0, 32'h0,  0, 5'd0, 0, 5'd0,  32'h0);
    tbl[7] = V(1, 5'd31, 32'hFFFF_FFFF, 0, 5'd0, 32'h0,  0, 5'd0, 1, 5'd31, 32'hFFFF_FFFF);

    resetn = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset rf_we", 32'(rf_we), 32'd0);
    chk("reset rf_waddr", 32'(rf_waddr), 32'd0);
    chk("reset rf_wdata", rf_wdata, 32'd0);
    chk("reset busy", busy, 32'd0);
    chk("reset pipe_stall", 32'(pipe_stall), 32'd0);
    chk("reset waw_err", 32'(waw_err), 32'd0);
    chk("reset lr_ready", 32'(lr_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run(tbl[i]);
      if (i == 1 || i == 2) chk("busy r5 pending", busy, 32'h0000_0020);
      if (i == 3) chk("busy r5 cleared at pop", busy, 32'h0);
    end

    // Starvation: one queued entry behind a continuously writing pipe.
    run(V(1, 5'd1, 32'h100, 1, 5'd10, 32'hA0, 0, 5'd0, 1, 5'd1, 32'h100));
    chk("stall after enqueue", 32'(pipe_stall), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      run(V(1, 5'(k + 1), 32'(k), 0, 5'd0, 32'h0, 0, 5'd0, 1, 5'(k + 1), 32'(k)));
      chk("starve stall", 32'(pipe_stall), (k == 4) ? 32'd1 : 32'd0);
    end
    run(V(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd10, 32'hA0));
    chk("stall falls after pop", 32'(pipe_stall), 32'd0);
    chk("waw_err clean", 32'(waw_err), 32'd0);

    // Full FIFO: four enqueues while the pipe holds the port, then a held fifth.
    for (int k = 0; k < 4; k++)
      run(V(1, 5'(k + 1), 32'(k), 1, 5'(11 + k), 32'hB1 + 32'(k), 0, 5'd0, 1, 5'(k + 1), 32'(k)));
    chk("full lr_ready", 32'(lr_ready), 32'd0);
    chk("full pipe_stall", 32'(pipe_stall), 32'd1);
    run(V(0, 5'd0, 32'h0, 1, 5'd15, 32'hB5, 0, 5'd0, 1, 5'd11, 32'hB1));
    chk("ready after pop", 32'(lr_ready), 32'd1);
    chk("stall after pop", 32'(pipe_stall), 32'd0);
    run(V(0, 5'd0, 32'h0, 1, 5'd15, 32'hB5, 0, 5'd0, 1, 5'd12, 32'hB2));
    run(V(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd13, 32'hB3));
    run(V(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd14, 32'hB4));
    run(V(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 1, 5'd15, 32'hB5));
    run(V(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0));
    chk("drained lr_ready", 32'(lr_ready), 32'd1);

    // r0 suppression and same-cycle set/clear of a busy bit.
    run(V(0, 5'd0, 32'h0, 1, 5'd0, 32'h77, 1, 5'd6, 0, 5'd0, 32'h0));
    run(V(0, 5'd0, 32'h0, 1, 5'd6, 32'h66, 0, 5'd0, 0, 5'd0, 32'h0));
    run(V(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  1, 5'd6, 1, 5'd6, 32'h66));
    chk("busy set wins", busy, 32'h0000_0040);
    run(V(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  1, 5'd0, 0, 5'd0, 32'h0));
    chk("busy r0 never set", busy, 32'h0000_0040);
    run(V(0, 5'd0, 32'h0, 1, 5'd6, 32'h67, 0, 5'd0, 0, 5'd0, 32'h0));
    run(V(0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  0, 5'd0, 1, 5'd6, 32'h67));
    chk("busy r6 cleared", busy, 32'h0);

    // WAW error on busy register, then asynchronous reset with entries queued.
    run(V(0, 5'd0, 32'h0,  0, 5'd0,  32'h0,  1, 5'd7,  0, 5'd0, 32'h0));
    chk("busy r7", busy, 32'h0000_0080);
    run(V(1, 5'd7, 32'h70, 0, 5'd0,  32'h0,  0, 5'd0,  1, 5'd7, 32'h70));
    chk("waw_err set", 32'(waw_err), 32'd1);
    run(V(0, 5'd0, 32'h0,  0, 5'd0,  32'h0,  0, 5'd0,  0, 5'd0, 32'h0));
    chk("waw_err sticky", 32'(waw_err), 32'd1);
    run(V(1, 5'd1, 32'h1,  1, 5'd20, 32'hC0, 1, 5'd20, 1, 5'd1, 32'h1));
    run(V(1, 5'd2, 32'h2,  1, 5'd21, 32'hC1, 0, 5'd0,  1, 5'd2, 32'h2));
    run(V(1, 5'd3, 32'h3,  1, 5'd22, 32'hC2, 0, 5'd0,  1, 5'd3, 32'h3));
    chk("busy before reset", busy, 32'h0010_0080);
    drive_idle();
    resetn = 1'b0;
    #2;
    chk("async rst rf_we", 32'(rf_we), 32'd0);
    chk("async rst busy", busy, 32'd0);
    chk("async rst lr_ready", 32'(lr_ready), 32'd1);
    chk("async rst waw_err", 32'(waw_err), 32'd0);
    chk("async rst stall", 32'(pipe_stall), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    run(V(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0));
    run(V(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0));
    chk("post reset empty", 32'(lr_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
